mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter between the CPU's instruction-fetch path and its load/store path, in front of a single shared, variable-latency memory port. It serialises requests, holds the losing requester off until its turn, returns read data and a one-cycle acknowledge to the winner, and aborts transactions the memory never answers. It sits between `RiscVCPU` (IF and MEM stages) and the unified instruction/data memory.

## Interface
- `ADDR_W`, 32: address width, byte addressed.
- `DATA_W`, 32: data width; `DATA_W/8` byte strobes.
- `TIMEOUT`, 255: maximum cycles to wait for `m_ack`; range 1..255.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request, held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched word, valid while `if_ack`=1.
- `if_ack`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  data request, held until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_wstrb`  in  DATA_W/8  store byte enables.
- `d_rdata`  out  DATA_W  load data, valid while `d_ack`=1.
- `d_ack`  out  1  one-cycle data completion pulse.
- `m_req`  out  1  memory request, held until `m_ack` sampled.
- `m_we`, `m_addr`, `m_wdata`, `m_wstrb`  out  1/ADDR_W/DATA_W/DATA_W/8  registered command fields.
- `m_rdata`  in  DATA_W  memory read data, valid with `m_ack`.
- `m_ack`  in  1  memory completion, one-cycle pulse.
- `err`  out  1  pulses with `if_ack`/`d_ack` when the transaction timed out.
- `grant`  out  1  0 = fetch owns memory, 1 = data; meaningful while `busy`.
- `busy`  out  1  high in `MEM` and `RESP`.

## Operation
- FSM states: `IDLE`, `MEM`, `RESP`.
- `IDLE`: if any request is high, choose a winner, latch its command fields into `m_*`, set `grant`, clear the timeout counter, and go to `MEM`. Fetch commands drive `m_we`=0 and `m_wstrb`=0.
- Winner selection: a single requester always wins. If both request at once, data wins (fixed priority).
- `MEM`: `m_req`=1 with stable fields. On `m_ack`=1, capture `m_rdata`, set `err`=0, and go to `RESP`. If the counter reaches `TIMEOUT` without `m_ack`, capture 0, set `err`=1, drop `m_req`, and go to `RESP`. The counter is 8-bit and saturates; it never wraps.
- `RESP`: pulse `if_ack` or `d_ack` according to `grant`, and drive the captured word on the matching `*_rdata`. `m_req`=0. Always return to `IDLE`.
- Stores also return the captured `m_rdata`; requesters ignore it.
- Requests are ignored outside `IDLE`. A requester must drop `req` (or present a new request) in the cycle after its ack.
- An `m_ack` arriving outside `MEM` (late ack after a timeout) is ignored.
- Reset (asynchronous, at any time): state `IDLE`; all outputs 0 (`m_req`, `m_*`, `*_ack`, `*_rdata`, `err`, `grant`, `busy`); counter 0. A transaction in flight is dropped with no ack.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Request sampled in `IDLE` at edge 0: `m_req` high after edge 0.
- `m_ack` sampled at edge k: ack pulse high for exactly one cycle after edge k.
- Zero-wait memory (`m_ack` in the first `MEM` cycle): request to ack is 2 cycles.
- Minimum issue spacing is 3 cycles (`IDLE`→`MEM`→`RESP`→`IDLE`).
- Timeout: ack with `err` comes `TIMEOUT`+1 cycles after entering `MEM`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests, grant goes to the requester that did not win the previous grant.
  - A `last_grant` register, reset to fetch, is updated on every grant, so the first tie after reset goes to data.
- Not defined: fixed priority, data over fetch; no `last_grant` register.

## Test plan
- Single load, memory acks in the first `MEM` cycle with `m_rdata`=0xDEADBEEF:
  - `m_req` high 1 cycle after `d_req`, `m_we`=0.
  - `d_ack` one cycle, 2 cycles after `d_req`, with `d_rdata`=0xDEADBEEF and `err`=0.
- Store with `d_wstrb`=4'b0011 and `d_addr`=0x100, memory waits 5 cycles:
  - `m_we`=1, `m_wstrb`=0011, `m_addr`=0x100 stable all 5 cycles.
  - One `d_ack`; `if_ack` stays 0.
- `if_req` and `d_req` both held for 4 transactions:
  - Fixed build: all grants go to data until `d_req` drops, then fetch.
  - RR build: grants alternate data, fetch, data, fetch.
- Memory never acks, `TIMEOUT`=4:
  - `d_ack` and `err`=1 arrive 5 cycles after entering `MEM`, with `d_rdata`=0.
  - A late `m_ack` afterwards produces no extra ack.
- `reset` asserted low mid-`MEM`:
  - `m_req`, `busy`, and all acks go to 0 immediately, with no ack emitted.
  - A new fetch after release completes normally.
- Back-to-back fetches to 0x0, 0x4, 0x8 with zero-wait memory: acks 3 cycles apart with the matching data words.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of one shared variable-latency memory port.
// Optional MEM_ARB_ROUND_ROBIN_EN alternates grants on ties; default is data-first priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_ack,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ack,
  output logic                  err,
  output logic                  grant,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e              r_state, w_state_d;
  logic [7:0]          r_cnt;
  logic                w_any_req, w_pick_d, w_issue, w_timeout, w_done;
  logic                w_m_req_d, w_busy_d, w_if_ack_d, w_d_ack_d, w_err_d;
  logic [DATA_W-1:0]   w_rdata_d;

  logic                r_m_req, r_m_we, r_grant, r_busy, r_if_ack, r_d_ack, r_err;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata, r_if_rdata, r_d_rdata;
  logic [DATA_W/8-1:0] r_m_wstrb;

  assign w_any_req = if_req | d_req;
  assign w_issue   = (r_state == StIdle) && w_any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // On a tie the previous loser wins; reset value (fetch) hands the first tie to data.
  assign w_pick_d = (if_req & d_req) ? ~r_last_grant : d_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b0;
    end else if (w_issue) begin
      r_last_grant <= w_pick_d;
    end
  end
`else
  assign w_pick_d = d_req;
`endif

  assign w_timeout = (r_cnt >= TimeoutCnt);
  assign w_done    = (r_state == StMem) && (m_ack || w_timeout);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_any_req) w_state_d = StMem;
      StMem:   if (m_ack || w_timeout) w_state_d = StResp;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Next values for the registered outputs; m_ack wins over a same-cycle timeout.
  always_comb begin
    w_m_req_d  = (w_state_d == StMem);
    w_busy_d   = (w_state_d != StIdle);
    w_if_ack_d = w_done & ~r_grant;
    w_d_ack_d  = w_done & r_grant;
    w_err_d    = w_done & ~m_ack;
    w_rdata_d  = (w_done && m_ack) ? m_rdata : '0;
  end

  // Saturating wait counter, cleared while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 8'd0;
    end else if (r_state == StIdle) begin
      r_cnt <= 8'd0;
    end else if (r_state == StMem && r_cnt != 8'hFF) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m_req    <= 1'b0;
      r_busy     <= 1'b0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_err      <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_grant    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_wstrb  <= '0;
    end else begin
      r_m_req    <= w_m_req_d;
      r_busy     <= w_busy_d;
      r_if_ack   <= w_if_ack_d;
      r_d_ack    <= w_d_ack_d;
      r_err      <= w_err_d;
      r_if_rdata <= w_if_ack_d ? w_rdata_d : '0;
      r_d_rdata  <= w_d_ack_d ? w_rdata_d : '0;
      if (w_issue) begin
        r_grant   <= w_pick_d;
        r_m_we    <= w_pick_d & d_we;
        r_m_addr  <= w_pick_d ? d_addr : if_addr;
        r_m_wdata <= w_pick_d ? d_wdata : '0;
        r_m_wstrb <= w_pick_d ? d_wstrb : '0;
      end
    end
  end

  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign m_wstrb  = r_m_wstrb;
  assign if_ack   = r_if_ack;
  assign d_ack    = r_d_ack;
  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;
  assign err      = r_err;
  assign grant    = r_grant;
  assign busy     = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: each transaction's winner, ack timing, data and
// error flag are predicted from the arbitration and timeout rules.
module tb_mem_arbiter;

  localparam int To = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, m_ack;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_wstrb;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_ack, d_ack, m_req, m_we, err, grant, busy;
  logic [3:0]  m_wstrb;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ack_cyc  = 0;
  logic model_last = 1'b0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(To)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wstrb  (d_wstrb),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_rdata  (m_rdata),
    .m_ack    (m_ack),
    .err      (err),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // Called at a negedge with the arbiter idle; returns at a negedge with it idle again.
  task automatic run_txn(input logic fi, input logic di, input logic [31:0] ia,
                         input logic [31:0] da, input logic we, input logic [31:0] wd,
                         input logic [3:0] ws, input int lat, input logic [31:0] rd);
    logic        w;
    logic        timed_out;
    int          exp_edge;
    logic [36:0] cmd;
    check_eq("idle", {busy, if_ack, d_ack, m_req, err}, 0);
    if_req = fi; if_addr = ia;
    d_req = di; d_we = we; d_addr = da; d_wdata = wd; d_wstrb = ws;
    if (fi && di) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w = ~model_last;
`else
      w = 1'b1;
`endif
    end else begin
      w = di;
    end
    model_last = w;
    timed_out  = (lat > To);
    exp_edge   = (timed_out ? To : lat) + 1;
    cmd        = w ? {we, ws, da} : {1'b0, 4'b0, ia};
    @(negedge clk);
    check_eq("grant", {busy, m_req, grant}, {2'b11, w});
    check_eq("cmd", {m_we, m_wstrb, m_addr}, cmd);
    if (w) check_eq("wdata", m_wdata, wd);
    for (int n = 1; n <= exp_edge; n++) begin
      m_ack   = (n - 1 == lat);
      m_rdata = (n - 1 == lat) ? rd : $urandom;
      @(negedge clk);
      m_ack = 1'b0;
      if (n < exp_edge)
        check_eq("wait", {if_ack, d_ack, err, m_req, m_we, m_wstrb, m_addr}, {4'b0001, cmd});
    end
    ack_cyc = cyc;
    check_eq("ack", {if_ack, d_ack, err}, {~w, w, timed_out});
    check_eq("rdata", w ? d_rdata : if_rdata, timed_out ? 32'h0 : rd);
    check_eq("mreq_drop", {m_req, busy}, 2'b01);
    if_req = 1'b0; d_req = 1'b0;
    if (timed_out) begin
      m_ack = 1'b1;
      m_rdata = $urandom;
    end
    @(negedge clk);
    m_ack = 1'b0;
    check_eq("one_shot", {if_ack, d_ack, err, busy}, 0);
  endtask

  initial begin
    int prev;
    reset = 1'b0;
    if_req = 0; d_req = 0; d_we = 0; m_ack = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0; d_wstrb = 0;
    @(negedge clk);
    check_eq("reset", {m_req, m_we, m_wstrb, m_addr, if_ack, d_ack, err, grant, busy}, 0);
    check_eq("reset_rdata", {if_rdata, d_rdata}, 0);
    reset = 1'b1;
    @(negedge clk);

    // Zero-wait load, then a store held off by five wait cycles.
    run_txn(0, 1, 32'h0, 32'h40, 0, 32'h0, 4'h0, 0, 32'hDEADBEEF);
    run_txn(0, 1, 32'h0, 32'h100, 1, 32'h12345678, 4'b0011, 5, 32'h0BADF00D);

    // Both requesters held together for four transactions.
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 32'h200 + 32'(i * 4), 32'h300 + 32'(i * 4), 0, 0, 0, 1, $urandom);

    // Memory never answers; a late m_ack is injected inside run_txn.
    run_txn(0, 1, 32'h0, 32'h500, 0, 0, 0, 100, 32'hFFFFFFFF);

    // Back-to-back zero-wait fetches land three cycles apart.
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      run_txn(1, 0, 32'(i * 4), 32'h0, 0, 0, 0, 0, 32'hA000_0000 + 32'(i));
      if (i > 0) check_eq("spacing", 64'(ack_cyc - prev), 64'd3);
      prev = ack_cyc;
    end

    // Asynchronous reset in the middle of a memory wait.
    if_req = 1'b1; if_addr = 32'h700;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_eq("rst_mid", {m_req, m_we, m_wstrb, m_addr, if_ack, d_ack, err, grant, busy}, 0);
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_last = 1'b0;
    @(negedge clk);
    check_eq("rst_noack", {if_ack, d_ack, busy, m_req}, 0);
    run_txn(1, 0, 32'h704, 32'h0, 0, 0, 0, 2, 32'hC0DEC0DE);

    for (int i = 0; i < 40; i++) begin
      int unsigned pat;
      pat = $urandom_range(1, 3);
      run_txn(pat[1], pat[0], $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
              1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, To + 2)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
